// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared constants and source-code encoding for the operand forwarding stage
package fwd_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_AW    = 5;
    localparam int SRC_RF    = 0;
    localparam int REG_ZERO  = 0;

    // Source code is 2 bits up to three sources, then grows to hold NSRC+1 codes.
    function automatic int src_w(input int nsrc);
        return (nsrc <= 3) ? 2 : $clog2(nsrc + 1);
    endfunction
endpackage

// File: rtl/fwd_prio_sel.sv
// rtl/fwd_prio_sel.sv - fixed-priority forwarding source select by register-number match
import fwd_pkg::*;

module fwd_prio_sel #(
    parameter int NSRC  = 3,
    parameter int AW    = DEF_AW,
    parameter int WIDTH = DEF_WIDTH,
    parameter int SW    = src_w(NSRC)
) (
    input  logic [AW-1:0]         src_addr,
    input  logic [NSRC*AW-1:0]    fwd_addr,
    input  logic [NSRC-1:0]       fwd_wen,
    input  logic [NSRC-1:0]       fwd_ready,
    input  logic [NSRC*WIDTH-1:0] fwd_data,
    input  logic [WIDTH-1:0]      rf_data,
    output logic                  match,
    output logic [SW-1:0]         sel,
    output logic [WIDTH-1:0]      sel_data,
    output logic                  ready_of_sel
);
    logic addr_nonzero;

    assign addr_nonzero = (src_addr != AW'(REG_ZERO));

    always_comb begin
        match        = 1'b0;
        sel          = SW'(SRC_RF);
        sel_data     = rf_data;
        ready_of_sel = 1'b1;
        // Walk oldest to youngest so the youngest hit overwrites the result.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (fwd_wen[i] && addr_nonzero && (fwd_addr[i*AW +: AW] == src_addr)) begin
                match        = 1'b1;
                sel          = SW'(i + 1);
                sel_data     = fwd_data[i*WIDTH +: WIDTH];
                ready_of_sel = fwd_ready[i];
            end
        end
        if (!addr_nonzero) begin
            sel_data = '0;
        end
    end
endmodule

// File: rtl/fwd_operand_stage.sv
// rtl/fwd_operand_stage.sv - forwarded operand register with stall/flush/load-use hazard
// Optional counters under FWD_OPERAND_STATS_EN.
import fwd_pkg::*;

module fwd_operand_stage #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NSRC  = 3,
    parameter int AW    = DEF_AW,
    parameter int SW    = src_w(NSRC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [AW-1:0]         src_addr,
    input  logic [WIDTH-1:0]      rf_data,
    input  logic [NSRC*AW-1:0]    fwd_addr,
    input  logic [NSRC*WIDTH-1:0] fwd_data,
    input  logic [NSRC-1:0]       fwd_wen,
    input  logic [NSRC-1:0]       fwd_ready,
    input  logic                  stall_in,
    input  logic                  flush,
    output logic                  hazard,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SW-1:0]         out_src
`ifdef FWD_OPERAND_STATS_EN
    ,
    output logic [31:0]           fwd_count,
    output logic [31:0]           haz_count
`endif
);
    logic             match;
    logic [SW-1:0]    sel;
    logic [WIDTH-1:0] sel_data;
    logic             ready_of_sel;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] out_data_d,  out_data_q;
    logic [SW-1:0]    out_src_d,   out_src_q;

    fwd_prio_sel #(
        .NSRC  (NSRC),
        .AW    (AW),
        .WIDTH (WIDTH),
        .SW    (SW)
    ) u_sel (
        .src_addr     (src_addr),
        .fwd_addr     (fwd_addr),
        .fwd_wen      (fwd_wen),
        .fwd_ready    (fwd_ready),
        .fwd_data     (fwd_data),
        .rf_data      (rf_data),
        .match        (match),
        .sel          (sel),
        .sel_data     (sel_data),
        .ready_of_sel (ready_of_sel)
    );

    assign hazard = in_valid && match && !ready_of_sel;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (flush) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_src_d   = SW'(SRC_RF);
        end else if (stall_in) begin
            out_valid_d = out_valid_q;
        end else if (hazard) begin
            // Bubble: upstream holds its inputs and we retry next cycle.
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = in_valid;
            out_data_d  = sel_data;
            out_src_d   = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= SW'(SRC_RF);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

`ifdef FWD_OPERAND_STATS_EN
    logic [31:0] fwd_count_d, fwd_count_q;
    logic [31:0] haz_count_d, haz_count_q;

    always_comb begin
        fwd_count_d = fwd_count_q;
        haz_count_d = haz_count_q;
        if (!flush && !stall_in && !hazard && in_valid && match && (fwd_count_q != '1)) begin
            fwd_count_d = fwd_count_q + 32'd1;
        end
        if (hazard && !stall_in && (haz_count_q != '1)) begin
            haz_count_d = haz_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fwd_count_q <= '0;
            haz_count_q <= '0;
        end else begin
            fwd_count_q <= fwd_count_d;
            haz_count_q <= haz_count_d;
        end
    end

    assign fwd_count = fwd_count_q;
    assign haz_count = haz_count_q;
`endif
endmodule
